// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared types for the bank access controller.
// Power state encoding, request bundle and default idle timeout.
package mem_ctrl_pkg;

   localparam int IDLE_TIMEOUT_DEF = 8;
   localparam int REQ_ADDR_MAX     = 32;
   localparam int REQ_DATA_MAX     = 64;

   typedef enum logic [1:0] {
      SLEEP  = 2'd0,
      WAKE   = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   // widest supported request; narrower banks zero-extend into it
   typedef struct packed {
      logic                    write;
      logic [REQ_ADDR_MAX-1:0] addr;
      logic [REQ_DATA_MAX-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_bank_access_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over a request vector.
// Pointer moves one past the winner after every grant.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         en,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] r_ptr;
   logic [PW-1:0] w_idx;
   logic [PW-1:0] w_nxt;
   logic          w_any;

   // first requester at or after the pointer wins
   always_comb begin
      gnt   = '0;
      w_idx = '0;
      w_nxt = r_ptr;
      w_any = 1'b0;
      for (int k = 0; k < N; k++) begin
         w_idx = PW'((32'(r_ptr) + 32'(k)) % 32'(N));
         if (en && req[w_idx] && !w_any) begin
            gnt[w_idx] = 1'b1;
            w_nxt      = PW'((32'(w_idx) + 32'd1) % 32'(N));
            w_any      = 1'b1;
         end
      end
   end

   // advance the pointer past the winner
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (w_any) begin
         r_ptr <= w_nxt;
      end
   end

endmodule

// File: rtl/mem_bank_access_ctrl.sv
// mem_bank_access_ctrl: arbitrates N_REQ clients onto one
// single-port bank, routes read data, gates chip-enable when idle.
module mem_bank_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 16,
   parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ-1:0]        req_write,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   input  logic [N_REQ*DATA_W-1:0] req_wdata,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    bank_chip_en,
   output logic                    bank_wr_en,
   output logic [ADDR_W-1:0]       bank_wr_addr,
   output logic [DATA_W-1:0]       bank_wr_data,
   output logic                    bank_rd_en,
   output logic [ADDR_W-1:0]       bank_rd_addr,
   input  logic [DATA_W-1:0]       bank_rd_data
);

   localparam int CW = $clog2(IDLE_TIMEOUT + 1);

   state_t            r_state;
   logic [CW-1:0]     r_cnt;
   logic              r_chip_en;
   logic [N_REQ-1:0]  r_tag;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [ADDR_W-1:0] r_rd_addr;
   logic [DATA_W-1:0] r_wr_data;
   logic [DATA_W-1:0] r_rsp_data;

   logic [N_REQ-1:0]  w_gnt;
   logic              w_en;
   logic              w_any;
   logic              w_wr;
   logic              w_rd;
   logic              w_idle;
   mem_req_t          w_sel;

   assign w_en = (r_state == ACTIVE);

   rr_arbiter #(.N(N_REQ)) u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req_valid),
      .en    (w_en),
      .gnt   (w_gnt)
   );

   // select the granted client's request
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_gnt[i]) begin
            w_sel.write = req_write[i];
            w_sel.addr  = REQ_ADDR_MAX'(req_addr[i*ADDR_W +: ADDR_W]);
            w_sel.wdata = REQ_DATA_MAX'(req_wdata[i*DATA_W +: DATA_W]);
         end
      end
   end

   assign w_any  = |w_gnt;
   assign w_wr   = w_any & w_sel.write;
   assign w_rd   = w_any & ~w_sel.write;
   assign w_idle = ~(|req_valid) & ~(|r_tag);

   assign req_ready    = w_gnt;
   assign bank_chip_en = r_chip_en;
   assign bank_wr_en   = w_wr;
   assign bank_rd_en   = w_rd;
   assign bank_wr_addr = w_wr ? w_sel.addr[ADDR_W-1:0] : r_wr_addr;
   assign bank_wr_data = w_wr ? w_sel.wdata[DATA_W-1:0] : r_wr_data;
   assign bank_rd_addr = w_rd ? w_sel.addr[ADDR_W-1:0] : r_rd_addr;
   assign rsp_valid    = r_tag;
   assign rsp_data     = (|r_tag) ? bank_rd_data : r_rsp_data;

   // power FSM: wake on demand, sleep after a run of idle cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= SLEEP;
         r_chip_en <= 1'b0;
         r_cnt     <= '0;
      end else begin
         unique case (r_state)
            SLEEP: begin
               if (|req_valid) begin
                  r_state   <= WAKE;
                  r_chip_en <= 1'b1;
               end
            end
            WAKE: begin
               r_state   <= ACTIVE;
               r_chip_en <= 1'b1;
            end
            ACTIVE: begin
               if (!w_idle) begin
                  r_cnt <= '0;
               end else if (r_cnt == CW'(IDLE_TIMEOUT - 1)) begin
                  r_state   <= SLEEP;
                  r_chip_en <= 1'b0;
                  r_cnt     <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state   <= SLEEP;
               r_chip_en <= 1'b0;
               r_cnt     <= '0;
            end
         endcase
      end
   end

   // hold last issued bank fields, read tag and last read data
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tag      <= '0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_rd_addr  <= '0;
         r_rsp_data <= '0;
      end else begin
         r_tag <= w_gnt & {N_REQ{w_rd}};
         if (w_wr) begin
            r_wr_addr <= w_sel.addr[ADDR_W-1:0];
            r_wr_data <= w_sel.wdata[DATA_W-1:0];
         end
         if (w_rd) begin
            r_rd_addr <= w_sel.addr[ADDR_W-1:0];
         end
         if (|r_tag) begin
            r_rsp_data <= bank_rd_data;
         end
      end
   end

   // bank protocol invariants; also checks the request zero-extension
   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (!(w_wr && w_rd));
         assert (!(w_wr || w_rd) || r_chip_en);
         assert ($onehot0(w_gnt));
         assert ($onehot0(r_tag));
         assert ((w_sel.addr >> ADDR_W) == '0);
         assert ((w_sel.wdata >> DATA_W) == '0);
      end
   end

endmodule

// File: tb/tb_mem_bank_access_ctrl.sv
// tb_mem_bank_access_ctrl: directed and random traffic against
// a cycle-level reference model of the bank controller.
module tb_mem_bank_access_ctrl;

   localparam int N  = 4;
   localparam int AW = 10;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  req_valid = '0;
   logic [N-1:0]  req_write = '0;
   logic [N*AW-1:0] req_addr = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  rsp_valid;
   logic [DW-1:0] rsp_data;
   logic          bank_chip_en;
   logic          bank_wr_en;
   logic [AW-1:0] bank_wr_addr;
   logic [DW-1:0] bank_wr_data;
   logic          bank_rd_en;
   logic [AW-1:0] bank_rd_addr;
   logic [DW-1:0] bank_rd_data = '0;

   int checks = 0;
   int errors = 0;
   int mode = 0;

   always #5 clk = ~clk;

   mem_bank_access_ctrl #(
      .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .IDLE_TIMEOUT(TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_data     (rsp_data),
      .bank_chip_en (bank_chip_en),
      .bank_wr_en   (bank_wr_en),
      .bank_wr_addr (bank_wr_addr),
      .bank_wr_data (bank_wr_data),
      .bank_rd_en   (bank_rd_en),
      .bank_rd_addr (bank_rd_addr),
      .bank_rd_data (bank_rd_data)
   );

   // the bank itself: registered read, write at the edge
   logic [DW-1:0] bank_mem [0:1023];
   always @(posedge clk) begin
      if (bank_wr_en) bank_mem[bank_wr_addr] <= bank_wr_data;
      if (bank_rd_en) bank_rd_data <= bank_mem[bank_rd_addr];
   end

   // reference model state (phase 0 asleep, 1 waking, 2 active)
   int            m_phase, m_ptr, m_idle, m_g;
   logic [N-1:0]  m_pend;
   logic [DW-1:0] m_pend_data, m_last_rsp, m_wd;
   logic [AW-1:0] m_wa, m_ra;
   logic [DW-1:0] m_mem [0:1023];

   logic [N-1:0]  e_ready, e_rsp_v;
   logic [DW-1:0] e_rsp_d, e_wd;
   logic          e_ce, e_we, e_re;
   logic [AW-1:0] e_wa, e_ra;

   logic [N-1:0]  o_ready, o_rsp_v;
   logic [DW-1:0] o_rsp_d;
   logic          o_ce, o_we, o_re;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_ptr = 0; m_idle = 0; m_g = -1;
      m_pend = '0; m_pend_data = '0; m_last_rsp = '0;
      m_wa = '0; m_ra = '0; m_wd = '0;
   endtask

   task automatic model_eval();
      m_g = -1;
      if (m_phase == 2) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (m_g < 0 && req_valid[c]) m_g = c;
         end
      end
      e_ready = '0;
      e_we = 1'b0; e_re = 1'b0;
      e_wa = m_wa; e_wd = m_wd; e_ra = m_ra;
      if (m_g >= 0) begin
         e_ready[m_g] = 1'b1;
         if (req_write[m_g]) begin
            e_we = 1'b1;
            e_wa = req_addr[m_g*AW +: AW];
            e_wd = req_wdata[m_g*DW +: DW];
         end else begin
            e_re = 1'b1;
            e_ra = req_addr[m_g*AW +: AW];
         end
      end
      e_ce    = (m_phase != 0);
      e_rsp_v = m_pend;
      e_rsp_d = (|m_pend) ? m_pend_data : m_last_rsp;
   endtask

   task automatic model_update();
      logic [N-1:0]  np;
      logic [DW-1:0] nd;
      logic          idle;
      np = '0;
      nd = m_pend_data;
      if (e_we) begin
         m_mem[e_wa] = e_wd; m_wa = e_wa; m_wd = e_wd;
      end
      if (e_re) begin
         np = e_ready; nd = m_mem[e_ra]; m_ra = e_ra;
      end
      if (m_g >= 0) m_ptr = (m_g + 1) % N;
      if (|m_pend) m_last_rsp = m_pend_data;
      idle = (req_valid == '0) && (m_pend == '0);
      m_pend = np;
      m_pend_data = nd;
      if (m_phase == 0) begin
         if (req_valid != '0) m_phase = 1;
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if (!idle) begin
         m_idle = 0;
      end else begin
         m_idle++;
         if (m_idle == TO) begin
            m_phase = 0; m_idle = 0;
         end
      end
      if (!rst_n) model_reset();
   endtask

   task automatic set_req(input int i, input logic v, input logic w,
                          input int a, input logic [DW-1:0] d);
      req_valid[i] = v;
      req_write[i] = w;
      req_addr[i*AW +: AW] = AW'(a);
      req_wdata[i*DW +: DW] = d;
   endtask

   task automatic drive();
      if (mode == 1) begin
         for (int i = 0; i < N; i++)
            if (!req_valid[i] || m_g == i)
               set_req(i, 1'b1, 1'b0, $urandom_range(0, 15), '0);
      end else if (mode == 2) begin
         if (!req_valid[1] || m_g == 1)
            set_req(1, 1'b1, 1'b1, 7, DW'($urandom));
         if (!req_valid[2] || m_g == 2)
            set_req(2, 1'b1, 1'b0, 7, '0);
      end else if (mode == 3) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || m_g == i) begin
               if ($urandom_range(0, 9) < 4)
                  set_req(i, 1'b1, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 15), DW'($urandom));
               else
                  set_req(i, 1'b0, 1'b0, 0, '0);
            end
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      model_eval();
      o_ready = req_ready; o_rsp_v = rsp_valid; o_rsp_d = rsp_data;
      o_ce = bank_chip_en; o_we = bank_wr_en; o_re = bank_rd_en;
      chk("ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rsp_v);
      chk("rsp_data", rsp_data, e_rsp_d);
      chk("chip_en", bank_chip_en, e_ce);
      chk("wr_en", bank_wr_en, e_we);
      chk("rd_en", bank_rd_en, e_re);
      chk("wr_addr", bank_wr_addr, e_wa);
      chk("wr_data", bank_wr_data, e_wd);
      chk("rd_addr", bank_rd_addr, e_ra);
      @(posedge clk);
      model_update();
      #1;
      drive();
   endtask

   task automatic wait_grant(input int i, input int max, output int n);
      n = 0;
      do begin
         cycle();
         n++;
      end while (!o_ready[i] && n < max);
      chk("grant_seen", o_ready[i], 1'b1);
   endtask

   function automatic int idx_of(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   initial begin
      int n, hi, g, pg;
      logic [N-1:0]  pr;
      logic [DW-1:0] cur_wd, lastw, rd_exp;
      logic          rd_pend;

      for (int a = 0; a < 1024; a++) begin
         bank_mem[a] = '0;
         m_mem[a] = '0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      cycle();
      rst_n = 1'b1;

      // write then read-back from sleep
      set_req(0, 1'b1, 1'b1, 3, 16'h00A5);
      wait_grant(0, 8, n);
      chk("wake_latency", n, 3);
      set_req(0, 1'b1, 1'b0, 3, '0);
      wait_grant(0, 4, n);
      chk("rd_back_to_back", n, 1);
      set_req(0, 1'b0, 1'b0, 0, '0);
      cycle();
      chk("rsp_v_a5", o_rsp_v, 4'b0001);
      chk("rsp_d_a5", o_rsp_d, 16'h00A5);

      // idle timeout then rewake
      hi = 0;
      for (int k = 0; k < 20; k++) begin
         cycle();
         if (o_ce) hi++;
         else break;
      end
      chk("idle_timeout", hi, TO);
      set_req(2, 1'b1, 1'b1, 5, DW'($urandom));
      wait_grant(2, 8, n);
      chk("rewake_latency", n, 3);
      set_req(2, 1'b0, 1'b0, 0, '0);

      // request lands on the last idle cycle
      repeat (TO - 1) cycle();
      set_req(1, 1'b1, 1'b0, 5, '0);
      cycle();
      chk("timeout_grant", o_ready, 4'b0010);
      chk("timeout_ce", o_ce, 1'b1);
      set_req(1, 1'b0, 1'b0, 0, '0);
      cycle();
      chk("timeout_ce_after", o_ce, 1'b1);

      // all four clients reading continuously
      for (int i = 0; i < N; i++)
         set_req(i, 1'b1, 1'b0, $urandom_range(0, 15), '0);
      mode = 1;
      pg = -1;
      pr = '0;
      for (int c = 0; c < 16; c++) begin
         cycle();
         g = idx_of(o_ready);
         chk("rr_no_bubble", |o_ready, 1'b1);
         if (pg >= 0) begin
            chk("rr_order", g, (pg + 1) % N);
            chk("rr_rsp", o_rsp_v, pr);
         end
         pg = g;
         pr = o_ready;
      end

      // alternating write/read to one address
      mode = 0;
      req_valid = '0;
      set_req(1, 1'b1, 1'b1, 7, DW'($urandom));
      set_req(2, 1'b1, 1'b0, 7, '0);
      mode = 2;
      lastw = '0;
      rd_exp = '0;
      rd_pend = 1'b0;
      for (int c = 0; c < 20; c++) begin
         cur_wd = req_wdata[DW +: DW];
         cycle();
         chk("alt_excl", o_we & o_re, 1'b0);
         if (rd_pend) begin
            chk("alt_rsp_v", o_rsp_v[2], 1'b1);
            chk("alt_rsp_d", o_rsp_d, rd_exp);
         end
         rd_pend = 1'b0;
         if (o_ready[1]) lastw = cur_wd;
         if (o_ready[2]) begin
            rd_pend = 1'b1;
            rd_exp = lastw;
         end
      end

      // random traffic
      mode = 3;
      repeat (300) cycle();

      // reset while a read is being issued
      mode = 0;
      req_valid = '0;
      set_req(0, 1'b1, 1'b1, 9, DW'($urandom));
      wait_grant(0, 12, n);
      set_req(0, 1'b0, 1'b0, 0, '0);
      set_req(3, 1'b1, 1'b0, 9, '0);
      rst_n = 1'b0;
      cycle();
      chk("rst_rd_grant", o_ready, 4'b1000);
      chk("rst_rd_en", o_re, 1'b1);
      rst_n = 1'b1;
      set_req(3, 1'b0, 1'b0, 0, '0);
      cycle();
      chk("rst_rsp_v", o_rsp_v, '0);
      chk("rst_rsp_d", o_rsp_d, '0);
      chk("rst_ce", o_ce, 1'b0);
      chk("rst_ready", o_ready, '0);
      repeat (3) cycle();
      chk("rst_rsp_v_late", o_rsp_v, '0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
